// File: rtl/step_sequencer_gated_if.sv
// step_sequencer_gated_if: bus between the step sequencer and its compute units.
//   unit_clk_en  per-unit clock-gate enable      (master -> slave)
//   unit_start   per-unit start, one-hot or zero (master -> slave)
//   unit_data_in operand to the active unit      (master -> slave)
//   unit_out     unit u result at [u*DW +: DW]   (slave -> master)
//   unit_done    per-unit done                   (slave -> master)
interface step_sequencer_gated_if #(
    parameter int DW        = 8,
    parameter int NUM_UNITS = 4
);
    logic [NUM_UNITS-1:0]    unit_clk_en;
    logic [NUM_UNITS-1:0]    unit_start;
    logic [DW-1:0]           unit_data_in;
    logic [NUM_UNITS*DW-1:0] unit_out;
    logic [NUM_UNITS-1:0]    unit_done;
    modport master (
        output unit_clk_en, unit_start, unit_data_in,
        input  unit_out, unit_done
    );
    modport slave (
        input  unit_clk_en, unit_start, unit_data_in,
        output unit_out, unit_done
    );
endinterface

// File: rtl/step_sequencer_gated.sv
// step_sequencer_gated: runs a latched program of unit steps with per-unit clock gating.
//   clk, rst_n      clock, asynchronous active-low reset
//   start, abort    start request (IDLE only), cancel running sequence
//   data_in         initial operand, loaded into the accumulator on accept
//   prog_unit       unit index of step i at [i*UW +: UW]
//   prog_len        number of steps to execute
//   bus             unit-side enables, starts, operand, results and dones
//   data_out        registered final result
//   done, err       one-cycle completion / error pulses
//   busy, cur_step  not-IDLE flag, index of the active step
module step_sequencer_gated #(
    parameter int  DW        = 8,
    parameter int  NUM_UNITS = 4,
    parameter int  NUM_STEPS = 8,
    parameter int  TIMEOUT   = 255,
    localparam int UW        = $clog2(NUM_UNITS),
    localparam int LW        = $clog2(NUM_STEPS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [DW-1:0]           data_in,
    input  logic [NUM_STEPS*UW-1:0] prog_unit,
    input  logic [LW-1:0]           prog_len,
    step_sequencer_gated_if.master  bus,
    output logic [DW-1:0]           data_out,
    output logic                    done,
    output logic                    busy,
    output logic                    err,
    output logic [LW-1:0]           cur_step
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ARM, RUN, ISO} state_t;

    state_t                  state_q, state_d;
    logic [NUM_STEPS*UW-1:0] prog_q, prog_d;
    logic [LW-1:0]           len_q, len_d;
    logic [LW-1:0]           cur_q, cur_d;
    logic [DW-1:0]           acc_q, acc_d;
    logic [DW-1:0]           data_out_q, data_out_d;
    logic [TW-1:0]           tcnt_q, tcnt_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    // Power-of-two sized views so every index width matches exactly.
    logic [UW-1:0] units [2**LW];
    logic [DW-1:0] outs  [2**UW];
    logic          dones [2**UW];

    for (genvar i = 0; i < 2**LW; i++) begin : g_step
        if (i < NUM_STEPS) begin : g_v
            assign units[i] = prog_q[i*UW +: UW];
        end else begin : g_z
            assign units[i] = '0;
        end
    end

    for (genvar i = 0; i < 2**UW; i++) begin : g_unit
        if (i < NUM_UNITS) begin : g_v
            assign outs[i]  = bus.unit_out[i*DW +: DW];
            assign dones[i] = bus.unit_done[i];
        end else begin : g_z
            assign outs[i]  = '0;
            assign dones[i] = 1'b0;
        end
    end

    logic [UW-1:0] u;
    logic [LW-1:0] step_nx;
    logic          last;
    logic          valid;

    assign u       = units[cur_q];
    assign step_nx = cur_q + LW'(1);
    assign last    = cur_q == len_q - LW'(1);

    // Only the fields inside the requested length must name a real unit.
    always_comb begin
        valid = prog_len != '0 && prog_len <= LW'(NUM_STEPS);
        for (int i = 0; i < NUM_STEPS; i++)
            if (LW'(i) < prog_len && {1'b0, prog_unit[i*UW +: UW]} >= (UW+1)'(NUM_UNITS))
                valid = 1'b0;
    end

    always_comb begin
        state_d    = state_q;
        prog_d     = prog_q;
        len_d      = len_q;
        cur_d      = cur_q;
        acc_d      = acc_q;
        data_out_d = data_out_q;
        tcnt_d     = tcnt_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                if (valid) begin
                    prog_d  = prog_unit;
                    len_d   = prog_len;
                    acc_d   = data_in;
                    cur_d   = '0;
                    state_d = ARM;
                end else begin
                    err_d = 1'b1;
                end
            end
            ARM: begin
                tcnt_d  = '0;
                state_d = abort ? IDLE : RUN;
            end
            RUN: begin
                // abort wins over a final done; done wins over timeout
                if (abort) begin
                    state_d = IDLE;
                end else if (dones[u]) begin
                    acc_d = outs[u];
                    if (last) begin
                        data_out_d = outs[u];
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        cur_d   = step_nx;
                        state_d = units[step_nx] == u ? ISO : ARM;
                    end
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            ISO: state_d = abort ? IDLE : ARM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            prog_q     <= '0;
            len_q      <= '0;
            cur_q      <= '0;
            acc_q      <= '0;
            data_out_q <= '0;
            tcnt_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            prog_q     <= prog_d;
            len_q      <= len_d;
            cur_q      <= cur_d;
            acc_q      <= acc_d;
            data_out_q <= data_out_d;
            tcnt_q     <= tcnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Enable spans ARM and RUN so the gated clock runs one cycle before start.
    assign bus.unit_clk_en  = (state_q == ARM || state_q == RUN) ? NUM_UNITS'(1) << u : '0;
    assign bus.unit_start   = state_q == RUN ? NUM_UNITS'(1) << u : '0;
    assign bus.unit_data_in = acc_q;
    assign data_out         = data_out_q;
    assign done             = done_q;
    assign err              = err_q;
    assign busy             = state_q != IDLE;
    assign cur_step         = cur_q;
endmodule
